// File: rtl/ins_encoder_loader.sv
// ins_encoder_loader: packs decoded instruction fields back into 32-bit
// instruction words and streams them into instruction memory, one write
// strobe per accepted bundle, starting at a word-aligned base address.
module ins_encoder_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int CNT_WIDTH  = 7
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [ADDR_WIDTH-1:0] BaseAddr,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [1:0]            Fmt,
    input  logic [5:0]            Opcode,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            rd,
    input  logic [15:0]           immediate,
    input  logic [25:0]           bits_26,
    input  logic                  Last,
    output logic                  MemWE,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [31:0]           MemDataIn,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic [CNT_WIDTH-1:0]  Count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]            FMT_R     = 2'b00;
    localparam logic [1:0]            FMT_I     = 2'b01;
    localparam logic [1:0]            FMT_BAD   = 2'b11;
    localparam logic [CNT_WIDTH-1:0]  DEPTH_C   = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] memaddr_q, memaddr_d;
    logic [31:0]           memdata_q, memdata_d;
    logic                  last_q, last_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  inready_q, memwe_q, busy_q, done_q;
    logic [CNT_WIDTH-1:0]  cnt_inc;
    logic [31:0]           packed_word;

    // Byte-offset bits of the base address are forced to zero, so they never reach logic.
    logic unused_base_lsbs;
    assign unused_base_lsbs = ^BaseAddr[1:0];

    // Reassemble an instruction word from its fields; J-type is the fallback for any non-R/I format.
    function automatic logic [31:0] pack_word(
        input logic [1:0]  fmt,
        input logic [5:0]  op,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [15:0] f_imm,
        input logic [25:0] f_b26
    );
        logic [31:0] w;
        case (fmt)
            FMT_R:   w = {op, f_rs, f_rt, f_rd, 11'b0};
            FMT_I:   w = {op, f_rs, f_rt, f_imm};
            default: w = {op, f_b26};
        endcase
        return w;
    endfunction

    assign packed_word = pack_word(Fmt, Opcode, rs, rt, rd, immediate, bits_26);
    assign cnt_inc     = cnt_q + CNT_ONE;

    // Next-state and datapath decisions for the load session.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        memaddr_d = memaddr_q;
        memdata_d = memdata_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    addr_d  = {BaseAddr[ADDR_WIDTH-1:2], 2'b00};
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // InReady is high throughout LOAD, so InValid alone completes a handshake.
                if (InValid) begin
                    if (Fmt != FMT_BAD) begin
                        memaddr_d = addr_q;
                        memdata_d = packed_word;
                        last_d    = Last;
                        state_d   = S_WRITE;
                    end else begin
                        err_d = 1'b1;
                        if (Last) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_WRITE: begin
                addr_d = addr_q + WORD_STEP;
                cnt_d  = cnt_inc;
                if (last_q || (cnt_inc == DEPTH_C)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
                // Session ran out of room before the source said it was finished.
                if ((cnt_inc == DEPTH_C) && !last_q) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; outputs are decoded from the next state so they line up with it.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            memaddr_q <= '0;
            memdata_q <= '0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            inready_q <= 1'b0;
            memwe_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            memaddr_q <= memaddr_d;
            memdata_q <= memdata_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            inready_q <= (state_d == S_LOAD);
            memwe_q   <= (state_d == S_WRITE);
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign InReady   = inready_q;
    assign MemWE     = memwe_q;
    assign MemAddr   = memaddr_q;
    assign MemDataIn = memdata_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Error     = err_q;
    assign Count     = cnt_q;

endmodule

// File: tb/tb_ins_encoder_loader.sv
// Testbench for ins_encoder_loader: directed scenarios plus randomized
// sessions, checked every cycle against an event-scheduling reference model.
module tb_ins_encoder_loader;

    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 7;

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic [AW-1:0] BaseAddr = '0;
    logic          InValid = 1'b0;
    logic          InReady;
    logic [1:0]    Fmt = '0;
    logic [5:0]    Opcode = '0;
    logic [4:0]    rs = '0, rt = '0, rd = '0;
    logic [15:0]   immediate = '0;
    logic [25:0]   bits_26 = '0;
    logic          Last = 1'b0;
    logic          MemWE;
    logic [AW-1:0] MemAddr;
    logic [31:0]   MemDataIn;
    logic          Busy, Done, Error;
    logic [CW-1:0] Count;

    ins_encoder_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .BaseAddr(BaseAddr),
        .InValid(InValid), .InReady(InReady), .Fmt(Fmt), .Opcode(Opcode),
        .rs(rs), .rt(rt), .rd(rd), .immediate(immediate), .bits_26(bits_26),
        .Last(Last), .MemWE(MemWE), .MemAddr(MemAddr), .MemDataIn(MemDataIn),
        .Busy(Busy), .Done(Done), .Error(Error), .Count(Count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference packing straight from the field layout of each format.
    function automatic logic [31:0] ref_pack(input logic [1:0] f, input logic [5:0] op,
                                             input logic [4:0] a, input logic [4:0] b,
                                             input logic [4:0] c, input logic [15:0] im,
                                             input logic [25:0] j);
        if (f == 2'b00) return (32'(op) << 26) | (32'(a) << 21) | (32'(b) << 16) | (32'(c) << 11);
        if (f == 2'b01) return (32'(op) << 26) | (32'(a) << 21) | (32'(b) << 16) | 32'(im);
        return (32'(op) << 26) | 32'(j);
    endfunction

    // Model: session-level variables plus a short schedule of future output events.
    bit          mvalid = 0;
    bit          m_busy = 0;
    logic [31:0] m_addr = '0, m_last_addr = '0, m_last_data = '0;
    int          m_cnt = 0;
    bit          m_err = 0;
    bit          e_we[4];
    bit          e_last[4];
    bit          e_done[4];
    int          cyc = 0;
    int          s, s1;
    bit          we_now, done_now, hs;
    logic [31:0] wlog_a[$];
    logic [31:0] wlog_d[$];

    // Compare outputs against the model mid-cycle, then advance the model across the coming edge.
    always @(negedge CLK) begin
        s  = cyc % 4;
        s1 = (cyc + 1) % 4;
        if (mvalid) begin
            chk("MemWE", 64'(MemWE), 64'(e_we[s]));
            chk("Done", 64'(Done), 64'(e_done[s]));
            chk("Busy", 64'(Busy), 64'(m_busy));
            chk("InReady", 64'(InReady), 64'(m_busy && !e_we[s] && !e_done[s]));
            chk("MemAddr", 64'(MemAddr), 64'(m_last_addr));
            chk("MemDataIn", 64'(MemDataIn), 64'(m_last_data));
            chk("Count", 64'(Count), 64'(m_cnt));
            chk("Error", 64'(Error), 64'(m_err));
        end
        if (MemWE === 1'b1) begin
            wlog_a.push_back(MemAddr);
            wlog_d.push_back(MemDataIn);
        end
        if (Reset === 1'b1) begin
            mvalid = 1; m_busy = 0; m_addr = '0; m_last_addr = '0; m_last_data = '0;
            m_cnt = 0; m_err = 0;
            for (int k = 0; k < 4; k++) begin
                e_we[k] = 0; e_last[k] = 0; e_done[k] = 0;
            end
        end else if (mvalid) begin
            we_now   = e_we[s];
            done_now = e_done[s];
            hs       = (InValid === 1'b1) && m_busy && !we_now && !done_now;
            e_we[s]  = 0;
            e_done[s] = 0;
            if (!m_busy) begin
                if (Start === 1'b1) begin
                    m_busy = 1;
                    m_addr = BaseAddr & 32'hFFFF_FFFC;
                    m_cnt  = 0;
                    m_err  = 0;
                end
            end else if (done_now) begin
                m_busy = 0;
            end else if (we_now) begin
                m_addr = m_addr + 32'd4;
                m_cnt  = m_cnt + 1;
                if (e_last[s] || m_cnt == DEPTH) e_done[s1] = 1;
                if (m_cnt == DEPTH && !e_last[s]) m_err = 1;
            end else if (hs) begin
                if (Fmt != 2'b11) begin
                    e_we[s1]    = 1;
                    e_last[s1]  = Last;
                    m_last_addr = m_addr;
                    m_last_data = ref_pack(Fmt, Opcode, rs, rt, rd, immediate, bits_26);
                end else begin
                    m_err = 1;
                    if (Last) e_done[s1] = 1;
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start(input logic [31:0] b);
        Start = 1'b1;
        BaseAddr = b;
        tick();
        Start = 1'b0;
        BaseAddr = $urandom;
    endtask

    task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] c, input logic [15:0] im,
                        input logic [25:0] j, input bit last, input int bound, output bit acc);
        Fmt = f; Opcode = op; rs = a; rt = b; rd = c; immediate = im; bits_26 = j; Last = last;
        InValid = 1'b1;
        acc = 0;
        for (int k = 0; k < bound; k++) begin
            if (InReady === 1'b1) begin
                tick();
                acc = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic idle_wait();
        bit ok;
        ok = 0;
        for (int k = 0; k < 40; k++) begin
            if (Busy === 1'b0) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=busy required=idle t=%0t", $time);
        end
    endtask

    task automatic chk_write(input int idx, input logic [31:0] a, input logic [31:0] d);
        if (idx < wlog_a.size()) begin
            chk("wr_addr", 64'(wlog_a[idx]), 64'(a));
            chk("wr_data", 64'(wlog_d[idx]), 64'(d));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n;
        logic [1:0] f;
        tick(); tick();
        Reset = 1'b0;
        chk("rst_Count", 64'(Count), 64'd0);
        chk("rst_MemAddr", 64'(MemAddr), 64'd0);

        // Single I-type word.
        wlog_a.delete(); wlog_d.delete();
        start(32'h0);
        send(2'b01, 6'b000001, 5'd1, 5'd2, 5'd0, 16'h0005, 26'h0, 1'b1, 20, acc);
        InValid = 1'b0;
        idle_wait();
        chk("t1_nwr", 64'(wlog_a.size()), 64'd1);
        chk_write(0, 32'h0, 32'h04220005);
        chk("t1_Count", 64'(Count), 64'd1);
        chk("t1_Error", 64'(Error), 64'd0);

        // Back-to-back R then J.
        wlog_a.delete(); wlog_d.delete();
        start(32'h40);
        send(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 20, acc);
        send(2'b10, 6'b111000, 5'd0, 5'd0, 5'd0, 16'h0, 26'h4, 1'b1, 20, acc);
        InValid = 1'b0;
        idle_wait();
        chk("t2_nwr", 64'(wlog_a.size()), 64'd2);
        chk_write(0, 32'h40, 32'h00221800);
        chk_write(1, 32'h44, 32'hE0000004);
        chk("t2_Count", 64'(Count), 64'd2);

        // Illegal format in the middle.
        wlog_a.delete(); wlog_d.delete();
        start(32'h103);
        send(2'b00, 6'd2, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0, 20, acc);
        send(2'b11, 6'd9, 5'd9, 5'd9, 5'd9, 16'h9, 26'h9, 1'b0, 20, acc);
        send(2'b01, 6'd3, 5'd7, 5'd8, 5'd0, 16'hBEEF, 26'h0, 1'b1, 20, acc);
        InValid = 1'b0;
        idle_wait();
        chk("t3_nwr", 64'(wlog_a.size()), 64'd2);
        chk_write(0, 32'h100, 32'h08853000);
        chk_write(1, 32'h104, 32'h0CE8BEEF);
        chk("t3_Error", 64'(Error), 64'd1);
        chk("t3_Count", 64'(Count), 64'd2);
        start(32'h200);
        chk("t3_ErrClr", 64'(Error), 64'd0);
        send(2'b10, 6'd2, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF, 1'b1, 20, acc);
        InValid = 1'b0;
        idle_wait();

        // Overflow: six bundles without Last into a four-word session.
        wlog_a.delete(); wlog_d.delete();
        start(32'h10);
        for (int i = 0; i < 6; i++) begin
            send(2'b01, 6'(i), 5'd1, 5'd1, 5'd0, 16'(i), 26'h0, 1'b0, 10, acc);
            chk("t4_acc", 64'(acc), 64'(i < 4));
        end
        InValid = 1'b0;
        idle_wait();
        chk("t4_nwr", 64'(wlog_a.size()), 64'd4);
        chk_write(3, 32'h1C, 32'h0C210003);
        chk("t4_Error", 64'(Error), 64'd1);
        chk("t4_Count", 64'(Count), 64'd4);
        chk("t4_InReady", 64'(InReady), 64'd0);

        // Reset coincident with a handshake.
        wlog_a.delete(); wlog_d.delete();
        start(32'h20);
        Fmt = 2'b01; Opcode = 6'd5; rs = 5'd1; rt = 5'd1; immediate = 16'h1234; Last = 1'b1;
        InValid = 1'b1;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        InValid = 1'b0;
        tick(); tick();
        chk("t5_nwr", 64'(wlog_a.size()), 64'd0);
        chk("t5_Busy", 64'(Busy), 64'd0);
        chk("t5_MemDataIn", 64'(MemDataIn), 64'd0);
        start(32'h30);
        send(2'b01, 6'd1, 5'd1, 5'd2, 5'd0, 16'h0005, 26'h0, 1'b1, 20, acc);
        InValid = 1'b0;
        idle_wait();
        chk("t5_nwr2", 64'(wlog_a.size()), 64'd1);
        chk_write(0, 32'h30, 32'h04220005);

        // Start held during LOAD.
        wlog_a.delete(); wlog_d.delete();
        start(32'h50);
        send(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 20, acc);
        Start = 1'b1;
        BaseAddr = 32'h999;
        send(2'b10, 6'b111000, 5'd0, 5'd0, 5'd0, 16'h0, 26'h4, 1'b1, 20, acc);
        Start = 1'b0;
        InValid = 1'b0;
        idle_wait();
        chk("t6_nwr", 64'(wlog_a.size()), 64'd2);
        chk_write(0, 32'h50, 32'h00221800);
        chk_write(1, 32'h54, 32'hE0000004);
        chk("t6_Count", 64'(Count), 64'd2);

        // Randomized sessions, including address wrap and stray Start pulses.
        for (int sess = 0; sess < 40; sess++) begin
            start(($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF6 : $urandom);
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                InValid = 1'b0;
                for (int g = $urandom_range(0, 2); g > 0; g--) tick();
                f = ($urandom_range(0, 6) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                if (i == 1) Start = ($urandom_range(0, 2) == 0);
                send(f, 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                     16'($urandom), 26'($urandom), (i == n - 1), 10, acc);
                Start = 1'b0;
                if (!acc) break;
            end
            InValid = 1'b0;
            idle_wait();
            tick();
        end

        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
